// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Memory-side responder for the CPU's byte-wide memory bus. Provides a
//   synchronous byte RAM (1-cycle read latency) and an IO window at
//   mem_a[17:16]==2'b11 holding a TX byte FIFO, an RX byte read port and a
//   sticky halt register.
//
// Ports
//   clk            system clock, all state on the rising edge
//   rst            asynchronous active-low reset
//   rdy            global enable; bus side frozen when low (TX drain continues)
//   mem_a          byte address; bits [17:0] decoded
//   mem_dout       write data from the controller
//   mem_wr         1 = write cycle, 0 = read cycle
//   mem_din        registered read data to the controller
//   io_buffer_full TX FIFO has at most one free slot
//   tx_data        FIFO head byte
//   tx_valid       FIFO non-empty
//   tx_ready       consumer accepts the head this cycle
//   rx_data        incoming byte
//   rx_valid       rx_data is valid
//   rx_pop         one-cycle pulse after an RX byte was consumed by a read
//   halt           sticky stop request from the program
//   tx_overflow    sticky, an IO store was dropped because the FIFO was full
module mem_io_responder #(
  parameter int ADDR_BITS = 17,
  parameter int TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        halt,
  output logic        tx_overflow
);

  localparam int DATA_W = 8;
  localparam int PW     = $clog2(TX_DEPTH);
  localparam int CW     = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);
  localparam logic [CW-1:0] NFULL_C = CW'(TX_DEPTH - 1);

  logic [DATA_W-1:0] ram  [0:(1 << ADDR_BITS) - 1];
  logic [DATA_W-1:0] fifo [0:TX_DEPTH - 1];

  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        count;

  logic                 io;
  logic [ADDR_BITS-1:0] idx;
  logic [2:0]           ofs;
  logic                 ram_we;
  logic                 push_req;
  logic                 push_ok;
  logic                 pop;
  logic                 rx_take;
  logic                 unused_hi;

  assign io        = (mem_a[17:16] == 2'b11);
  assign idx       = mem_a[ADDR_BITS-1:0];
  assign ofs       = mem_a[2:0];
  assign unused_hi = ^mem_a[31:18];

  assign ram_we   = rdy & mem_wr & ~io;
  assign push_req = rdy & mem_wr & io & (ofs == 3'd0);
  assign pop      = tx_valid & tx_ready;
  // A full FIFO still accepts a push on the edge that also pops the head:
  // the write lands in the slot being vacated.
  assign push_ok  = push_req & ((count != DEPTH_C) | pop);
  assign rx_take  = rdy & ~mem_wr & io & (ofs == 3'd0) & rx_valid;

  assign tx_valid       = (count != '0);
  assign tx_data        = fifo[rd_ptr];
  assign io_buffer_full = (count >= NFULL_C);

  // RAM and FIFO storage carry no reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx] <= mem_dout;
    if (push_ok) fifo[wr_ptr] <= mem_dout;
  end

  // Bus read stage: mem_din is valid one cycle after the address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_din <= '0;
      rx_pop  <= 1'b0;
    end else begin
      rx_pop <= rx_take;
      if (rdy && !mem_wr) begin
        if (!io)                mem_din <= ram[idx];
        else if (ofs == 3'd0)   mem_din <= rx_valid ? rx_data : 8'h00;
        else                    mem_din <= 8'h00;
      end
    end
  end

  // TX FIFO control and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      halt        <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && !push_ok) tx_overflow <= 1'b1;
      if (rdy && mem_wr && io && ofs == 3'd4) halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        halt;
  logic        tx_overflow;

  mem_io_responder #(.ADDR_BITS(17), .TX_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop), .halt(halt),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [7:0] v;
  } exp_t;

  exp_t       rd_q[$];
  logic [7:0] tx_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic       chk_rd   = 1'b0;
  logic       rd_pend  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: read responses one cycle after a tagged read,
  // TX bytes whenever the consumer handshake completes.
  always @(posedge clk) rd_pend <= chk_rd && rdy && rst;

  always @(negedge clk) begin
    exp_t e;
    if (rd_pend) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'(mem_din), 32'hFFFF_FFFF);
      else begin
        e = rd_q.pop_front();
        chk(e.nm, 32'(mem_din), 32'(e.v));
      end
    end
    if (rst && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) chk("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
      else chk("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
    end
  end

  task automatic bus(input logic [31:0] a, input logic [7:0] d, input logic w);
    mem_a = a; mem_dout = d; mem_wr = w;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(32'h0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus(a, d, 1'b1);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [7:0] exp);
    exp_t e;
    e.nm = nm; e.v = exp;
    rd_q.push_back(e);
    chk_rd = 1'b1;
    bus(a, 8'h00, 1'b0);
    chk_rd = 1'b0;
  endtask

  task automatic txw(input logic [7:0] d, input bit accept);
    if (accept) tx_q.push_back(d);
    bus(32'h0003_0000, d, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; mem_a = '0; mem_dout = '0; mem_wr = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_din", 32'(mem_din), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_halt", 32'(halt), 0);
    chk("rst_overflow", 32'(tx_overflow), 0);
    chk("rst_full", 32'(io_buffer_full), 0);
    chk("rst_rx_pop", 32'(rx_pop), 0);
    rst = 1'b1;
    idle(1);
    wr(32'h0, 8'h00);                  // make idle reads of address 0 deterministic

    // RAM round trip, mem_din held across a write cycle
    wr(32'h11, 8'h3C);
    rd("rd_0x11", 32'h11, 8'h3C);
    wr(32'h10, 8'hA5);
    chk("din_hold_on_write", 32'(mem_din), 32'h3C);
    rd("rd_0x10", 32'h10, 8'hA5);
    idle(1);

    // burst read
    wr(32'h100, 8'h11); wr(32'h101, 8'h22); wr(32'h102, 8'h33); wr(32'h103, 8'h44);
    rd("burst0", 32'h100, 8'h11);
    rd("burst1", 32'h101, 8'h22);
    rd("burst2", 32'h102, 8'h33);
    rd("burst3", 32'h103, 8'h44);
    idle(1);

    // ignored IO write offset
    wr(32'h0003_0002, 8'h77);
    chk("ignored_ofs_no_push", 32'(tx_valid), 0);
    idle(1);

    // TX path
    txw(8'h41, 1); txw(8'h42, 1);
    chk("tx_valid_after_push", 32'(tx_valid), 1);
    chk("tx_head", 32'(tx_data), 32'h41);
    tx_ready = 1'b1;
    idle(2);
    tx_ready = 1'b0;
    chk("tx_empty_after_drain", 32'(tx_valid), 0);

    // full / overflow
    for (int i = 0; i < 6; i++) txw(8'(8'h60 + i), 1);
    chk("full_at_6", 32'(io_buffer_full), 0);
    txw(8'h66, 1);
    chk("full_at_7", 32'(io_buffer_full), 1);
    txw(8'h67, 1);
    chk("no_ovf_at_8", 32'(tx_overflow), 0);
    tx_ready = 1'b1;
    txw(8'h69, 1);                     // push and pop together at count 8
    tx_ready = 1'b0;
    chk("no_ovf_push_pop", 32'(tx_overflow), 0);
    chk("full_after_push_pop", 32'(io_buffer_full), 1);
    txw(8'h6A, 0);
    chk("ovf_on_9th", 32'(tx_overflow), 1);
    tx_ready = 1'b1;
    idle(8);
    tx_ready = 1'b0;
    chk("empty_after_8_pops", 32'(tx_valid), 0);
    chk("ovf_sticky", 32'(tx_overflow), 1);

    // RX port
    rx_valid = 1'b1; rx_data = 8'h5A;
    rd("rx_read", 32'h0003_0000, 8'h5A);
    rx_valid = 1'b0;
    chk("rx_pop_pulse", 32'(rx_pop), 1);
    idle(1);
    chk("rx_pop_one_cycle", 32'(rx_pop), 0);
    rd("rx_read_empty", 32'h0003_0000, 8'h00);
    chk("rx_no_pop_empty", 32'(rx_pop), 0);
    rx_valid = 1'b1;
    rd("io_other_ofs", 32'h0003_0003, 8'h00);
    chk("rx_no_pop_other_ofs", 32'(rx_pop), 0);
    rx_valid = 1'b0;
    idle(1);

    // halt
    chk("halt_before", 32'(halt), 0);
    wr(32'h0003_0004, 8'hFF);
    chk("halt_set", 32'(halt), 1);
    idle(2);
    chk("halt_sticky", 32'(halt), 1);

    // rdy=0 freezes the bus side
    rd("rd_before_freeze", 32'h101, 8'h22);
    rdy = 1'b0;
    wr(32'h0003_0000, 8'h99);
    wr(32'h101, 8'hEE);
    bus(32'h102, 8'h00, 1'b0);
    chk("din_held_rdy0", 32'(mem_din), 32'h22);
    rx_valid = 1'b1; rx_data = 8'h12;
    bus(32'h0003_0000, 8'h00, 1'b0);
    chk("no_rx_pop_rdy0", 32'(rx_pop), 0);
    chk("din_held_rdy0_io", 32'(mem_din), 32'h22);
    rx_valid = 1'b0;
    rdy = 1'b1;
    chk("no_push_rdy0", 32'(tx_valid), 0);
    rd("ram_unchanged_rdy0", 32'h101, 8'h22);

    // TX drain continues while rdy=0
    txw(8'h55, 1);
    rdy = 1'b0; tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0; rdy = 1'b1;
    chk("drain_during_rdy0", 32'(tx_valid), 0);

    // asynchronous reset mid-transfer
    txw(8'h71, 0); txw(8'h72, 0); txw(8'h73, 0);
    chk("count3_valid", 32'(tx_valid), 1);
    rd("rd_before_reset", 32'h10, 8'hA5);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("async_tx_valid", 32'(tx_valid), 0);
    chk("async_mem_din", 32'(mem_din), 0);
    chk("async_halt", 32'(halt), 0);
    chk("async_overflow", 32'(tx_overflow), 0);
    chk("async_full", 32'(io_buffer_full), 0);
    tx_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);
    chk("post_reset_empty", 32'(tx_valid), 0);
    chk("post_reset_halt", 32'(halt), 0);

    chk("rd_q_drained", 32'(rd_q.size()), 0);
    chk("tx_q_drained", 32'(tx_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
